// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - host-side bus of the UART receive FIFO
interface uart_rx_fifo_if;
  logic       rd_strobe;
  logic       err_clr;
  logic [3:0] data_out;
  logic       nib_sel;
  logic       data_valid;
  logic       new_byte;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_strobe, err_clr,
    input  data_out, nib_sel, data_valid, new_byte, busy, frame_err, overrun
  );

  modport slave (
    input  rd_strobe, err_clr,
    output data_out, nib_sel, data_valid, new_byte, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with byte FIFO read out nibble-wise
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int PW   = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          rx_meta, rxs;
  logic [2:0]    state;
  logic [11:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [PW:0]   count, count_n;
  logic          nib_q, nib_n, valid_q, new_byte_q, frame_err_q, overrun_q;
  logic [3:0]    data_q, data_n;
  logic [7:0]    head_n;

  logic tick_half, tick_full, push_req, frame_bad, full, rd_ok, pop, push_ok, drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick_half = (cnt == 12'(HALF - 1));
  assign tick_full = (cnt == 12'(CLKS_PER_BIT - 1));
  assign push_req  = (state == S_STOP) && tick_full && rxs;
  assign frame_bad = (state == S_STOP) && tick_full && !rxs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt + 12'd1;
      case (state)
        S_IDLE: if (!rxs) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (tick_half) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rxs ? S_IDLE : S_DATA;
        end
        S_DATA: if (tick_full) begin
          cnt     <= '0;
          shreg   <= {rxs, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end
        S_STOP: if (tick_full) begin
          cnt   <= '0;
          state <= rxs ? S_IDLE : S_WAIT_HIGH;
        end
        // A held-low line (break) must go high before a new start is accepted.
        S_WAIT_HIGH: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign rd_ok   = bus.rd_strobe && valid_q;
  assign pop     = rd_ok && nib_q;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    count_n  = count + (PW+1)'(push_ok) - (PW+1)'(pop);
    rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
    nib_n    = rd_ok ? ~nib_q : nib_q;
    // The byte being written this cycle becomes the head when the FIFO would otherwise be empty.
    head_n   = (push_ok && (rd_ptr_n == wr_ptr)) ? shreg : mem[rd_ptr_n];
    data_n   = 4'd0;
    if (count_n != '0) data_n = nib_n ? head_n[7:4] : head_n[3:0];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      nib_q       <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 4'd0;
      new_byte_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_n;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      count       <= count_n;
      nib_q       <= nib_n;
      valid_q     <= (count_n != '0);
      data_q      <= data_n;
      new_byte_q  <= push_ok;
      frame_err_q <= frame_bad | (frame_err_q & ~bus.err_clr);
      overrun_q   <= drop | (overrun_q & ~bus.err_clr);
    end
  end

  assign bus.data_out   = data_q;
  assign bus.nib_sel    = nib_q;
  assign bus.data_valid = valid_q;
  assign bus.new_byte   = new_byte_q;
  assign bus.busy       = (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int C = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  logic mon_strobe = 1'b0;
  logic dir_strobe = 1'b0;
  logic err_clr_r = 1'b0;
  logic reader_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int nb_count = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if bus();
  assign bus.rd_strobe = mon_strobe | dir_strobe;
  assign bus.err_clr   = err_clr_r;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.new_byte) nb_count++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic strobe();
    @(posedge clk); #1 dir_strobe = 1'b1;
    @(posedge clk); #1 dir_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr_r = 1'b1;
    @(posedge clk); #1 err_clr_r = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_cycles);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (C) @(posedge clk);
    #1 rx = (stop_low_cycles == 0);
    if (stop_low_cycles > 0) begin
      repeat (stop_low_cycles) @(posedge clk);
      #1 rx = 1'b1;
    end else begin
      repeat (C) @(posedge clk);
    end
  endtask

  task automatic dir_read(output logic [7:0] b);
    int t;
    logic [3:0] lo;
    t = 0;
    b = 8'h00;
    @(negedge clk);
    while (!bus.data_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.data_valid) begin
      checks++;
      failures++;
      $display("FAIL dir_read_timeout actual=empty expected=data_valid");
    end else begin
      lo = bus.data_out;
      strobe();
      b = {bus.data_out, lo};
      strobe();
    end
  endtask

  // Monitor: drains the FIFO whenever enabled and compares against the scoreboard.
  initial begin : monitor
    logic [3:0] lo;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (reader_en && bus.data_valid) begin
        lo = bus.data_out;
        @(posedge clk); #1 mon_strobe = 1'b1;
        @(posedge clk); #1 mon_strobe = 1'b0;
        @(negedge clk);
        got = {bus.data_out, lo};
        @(posedge clk); #1 mon_strobe = 1'b1;
        @(posedge clk); #1 mon_strobe = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0h expected=none", got);
        end else begin
          chk("sb_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int nb0, k, busy_hi, t;
    logic exp_err;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.data_out, bus.nib_sel, bus.data_valid, bus.new_byte,
                        bus.busy, bus.frame_err, bus.overrun}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_outputs", {bus.data_out, bus.nib_sel, bus.data_valid, bus.new_byte,
                             bus.busy, bus.frame_err, bus.overrun}, 32'd0);

    // single byte 0xA5 with latency measurement
    k = -1;
    fork
      send_frame(8'hA5, 0);
      begin
        int n;
        @(negedge rx);
        n = 0;
        while (k < 0 && n < 200) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (bus.new_byte) k = n;
        end
      end
    join
    chk("a5_latency", k, 32'd79);
    @(negedge clk);
    chk("a5_low_nib", bus.data_out, 32'h5);
    chk("a5_nib_sel0", bus.nib_sel, 32'd0);
    chk("a5_valid", bus.data_valid, 32'd1);
    strobe();
    chk("a5_high_nib", bus.data_out, 32'hA);
    chk("a5_nib_sel1", bus.nib_sel, 32'd1);
    strobe();
    chk("a5_empty", bus.data_valid, 32'd0);
    chk("a5_nib_back", bus.nib_sel, 32'd0);
    strobe();
    chk("empty_strobe_ignored", {bus.nib_sel, bus.data_valid}, 32'd0);

    // 3-cycle glitch
    nb0 = nb_count;
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(negedge clk);
    busy_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_hi++;
    end
    chk("glitch_busy", busy_hi, 32'd0);
    chk("glitch_no_push", nb_count - nb0, 32'd0);
    chk("glitch_flags", {bus.frame_err, bus.overrun, bus.data_valid}, 32'd0);

    // 0x3C with stop held low for 20 bit times
    nb0 = nb_count;
    busy_hi = 0;
    fork
      send_frame(8'h3C, 20 * C);
      begin
        @(negedge rx);
        repeat (90) @(negedge clk);
        chk("break_frame_err", bus.frame_err, 32'd1);
        repeat (100) begin
          @(negedge clk);
          if (bus.busy) busy_hi++;
        end
      end
    join
    chk("break_busy", busy_hi, 32'd0);
    chk("break_no_push", nb_count - nb0, 32'd0);
    repeat (2 * C) @(posedge clk);
    send_frame(8'h42, 0);
    dir_read(b);
    chk("after_break_byte", b, 32'h42);
    chk("frame_err_sticky", bus.frame_err, 32'd1);
    pulse_err_clr();
    chk("frame_err_clr", bus.frame_err, 32'd0);

    // five bytes without reads
    nb0 = nb_count;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    @(negedge clk);
    chk("ovr_pushes", nb_count - nb0, 32'd4);
    chk("ovr_flag", bus.overrun, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      dir_read(b);
      chk("ovr_read", b, 32'(i));
    end
    chk("ovr_drained", bus.data_valid, 32'd0);
    pulse_err_clr();
    chk("ovr_clr", bus.overrun, 32'd0);

    // full FIFO: push coincides with the popping high-nibble strobe
    nb0 = nb_count;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 0);
    strobe();
    chk("full_nib_sel1", bus.nib_sel, 32'd1);
    fork
      send_frame(8'h15, 0);
      begin
        @(negedge rx);
        repeat (78) @(posedge clk);
        #1 dir_strobe = 1'b1;
        @(posedge clk);
        #1 dir_strobe = 1'b0;
      end
    join
    @(negedge clk);
    chk("coinc_no_overrun", bus.overrun, 32'd0);
    chk("coinc_pushes", nb_count - nb0, 32'd5);
    for (int i = 2; i <= 5; i++) begin
      dir_read(b);
      chk("coinc_read", b, 32'h10 + 32'(i));
    end
    chk("coinc_drained", bus.data_valid, 32'd0);

    // reset mid-DATA with two bytes buffered
    send_frame(8'h77, 0);
    send_frame(8'h88, 0);
    @(posedge clk); #1 rx = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("mid_busy", bus.busy, 32'd1);
    reset_n = 1'b0;
    rx = 1'b1;
    #2;
    chk("mid_rst_outputs", {bus.data_out, bus.nib_sel, bus.data_valid, bus.new_byte,
                            bus.busy, bus.frame_err, bus.overrun}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2 * C) @(posedge clk);
    send_frame(8'hFF, 0);
    dir_read(b);
    chk("post_rst_byte", b, 32'hFF);
    chk("post_rst_only", bus.data_valid, 32'd0);

    // randomized frames drained by the monitor
    reader_en = 1'b1;
    exp_err = 1'b0;
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom);
      if (n == 5 || $urandom_range(0, 4) == 0) begin
        send_frame(b, C);
        exp_err = 1'b1;
        repeat (3) @(posedge clk);
      end else begin
        exp_q.push_back(b);
        send_frame(b, 0);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    t = 0;
    while ((exp_q.size() != 0 || bus.data_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rand_drained", exp_q.size(), 32'd0);
    repeat (10) @(negedge clk);
    reader_en = 1'b0;
    chk("rand_frame_err", bus.frame_err, {31'd0, exp_err});
    chk("rand_overrun", bus.overrun, 32'd0);
    pulse_err_clr();
    chk("rand_err_clr", bus.frame_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
